// File: rtl/cl_axis_pkt_rr_arbiter.sv
// rtl/cl_axis_pkt_rr_arbiter.sv - packet-level round-robin AXIS arbiter
// Holds one source for a whole packet; one IDLE arbitration cycle separates packets.
module cl_axis_pkt_rr_arbiter #(
  parameter int num_src_p    = 4,
  parameter int data_width_p = 512,
  parameter int cnt_width_p  = 32
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  input  logic                                  en_i,
  input  logic [num_src_p*data_width_p-1:0]     s_tdata_i,
  input  logic [num_src_p*data_width_p/8-1:0]   s_tkeep_i,
  input  logic [num_src_p-1:0]                  s_tlast_i,
  input  logic [num_src_p-1:0]                  s_tvalid_i,
  output logic [num_src_p-1:0]                  s_tready_o,
  output logic [data_width_p-1:0]               m_tdata_o,
  output logic [data_width_p/8-1:0]             m_tkeep_o,
  output logic                                  m_tlast_o,
  output logic                                  m_tvalid_o,
  input  logic                                  m_tready_i,
  output logic [num_src_p-1:0]                  grant_o,
  output logic                                  busy_o,
  output logic [cnt_width_p-1:0]                pkt_cnt_o
);

  localparam int keep_width_lp = data_width_p / 8;
  localparam int idx_width_lp  = $clog2(num_src_p);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e                  state_r;
  logic [idx_width_lp-1:0] grant_idx_r;
  logic [idx_width_lp-1:0] rr_ptr_r;
  logic [num_src_p-1:0]    grant_r;
  logic [cnt_width_p-1:0]  pkt_cnt_r;
  logic [idx_width_lp-1:0] pick_idx;
  logic                    pick_found;
  logic                    busy;
  logic                    last_beat;
  int                      cand;

  assign busy = (state_r == BUSY);

  // Scan downward so the candidate closest to rr_ptr_r is written last and wins.
  always_comb begin
    pick_idx   = '0;
    pick_found = 1'b0;
    cand       = 0;
    for (int i = num_src_p - 1; i >= 0; i--) begin
      cand = int'(rr_ptr_r) + i;
      if (cand >= num_src_p) cand = cand - num_src_p;
      if (s_tvalid_i[idx_width_lp'(cand)]) begin
        pick_idx   = idx_width_lp'(cand);
        pick_found = 1'b1;
      end
    end
  end

  assign m_tdata_o  = busy ? s_tdata_i[grant_idx_r*data_width_p +: data_width_p] : '0;
  assign m_tkeep_o  = busy ? s_tkeep_i[grant_idx_r*keep_width_lp +: keep_width_lp] : '0;
  assign m_tlast_o  = busy & s_tlast_i[grant_idx_r];
  assign m_tvalid_o = busy & s_tvalid_i[grant_idx_r];
  assign s_tready_o = (busy && m_tready_i) ? grant_r : '0;
  assign last_beat  = m_tvalid_o & m_tready_i & m_tlast_o;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r     <= IDLE;
      grant_idx_r <= '0;
      rr_ptr_r    <= '0;
      grant_r     <= '0;
      pkt_cnt_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (en_i && pick_found) begin
            grant_idx_r       <= pick_idx;
            grant_r           <= '0;
            grant_r[pick_idx] <= 1'b1;
            state_r           <= BUSY;
          end
        end
        BUSY: begin
          // en_i is deliberately ignored here: a started packet always completes.
          if (last_beat) begin
            state_r   <= IDLE;
            grant_r   <= '0;
            rr_ptr_r  <= (grant_idx_r == idx_width_lp'(num_src_p - 1)) ? '0 : grant_idx_r + 1'b1;
            pkt_cnt_r <= pkt_cnt_r + 1'b1;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign grant_o   = grant_r;
  assign busy_o    = busy;
  assign pkt_cnt_o = pkt_cnt_r;

  a_grant_onehot: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    $onehot0(grant_o) && (busy_o == (grant_o != '0)));

endmodule
